conv_row_sequencer: RTL and testbench

CONV_ROW_SEQUENCER -- requirements
Module: conv_row_sequencer

---
 rtl/conv_pkg.sv | 16 +
 rtl/conv_weight_align.sv | 48 ++++
 rtl/conv_row_sequencer.sv | 125 ++++++++++++
 tb/tb_conv_row_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution row sequencer: state encoding and
// default geometry.
package conv_pkg;

    localparam int CONV_ADDR_W = 8;
    localparam int CONV_DATA_W = 8;
    localparam int CONV_K      = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } conv_state_e;

endpackage

// File: rtl/conv_weight_align.sv
// One-cycle alignment stage: delays the tap strobe by the BRAM read latency
// and presents the matching kernel row plus first/last-tap markers.
module conv_weight_align
    import conv_pkg::*;
#(
    parameter int DATA_W = CONV_DATA_W,
    parameter int K      = CONV_K,
    parameter int KW     = $clog2(K)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tap_en_i,
    input  logic [KW-1:0]           tap_k_i,
    input  logic [K*K*DATA_W-1:0]   kernel_i,
    output logic [K*DATA_W-1:0]     weight_o,
    output logic                    w_valid_o,
    output logic                    acc_first_o,
    output logic                    acc_last_o
);

    // Row 0 sits in the MSBs, so row k is packed element K-1-k.
    logic [K-1:0][K*DATA_W-1:0] rows;
    assign rows = kernel_i;

    logic [K*DATA_W-1:0] weight_q;
    logic                w_valid_q, acc_first_q, acc_last_q;

    // Register row/flags alongside the read so they line up with read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            weight_q    <= '0;
            w_valid_q   <= 1'b0;
            acc_first_q <= 1'b0;
            acc_last_q  <= 1'b0;
        end else begin
            w_valid_q   <= tap_en_i;
            acc_first_q <= tap_en_i && (tap_k_i == '0);
            acc_last_q  <= tap_en_i && (tap_k_i == KW'(K-1));
            weight_q    <= tap_en_i ? rows[KW'(K-1) - tap_k_i] : '0;
        end
    end

    assign weight_o    = weight_q;
    assign w_valid_o   = w_valid_q;
    assign acc_first_o = acc_first_q;
    assign acc_last_o  = acc_last_q;

endmodule

// File: rtl/conv_row_sequencer.sv
// Convolution row sequencer: walks K taps per output row over the input rows
// in BRAM, issuing registered reads and aligned kernel rows.
// Optional feature: define CONV_SEQ_STALL_EN to add a 'stall' input that
// suppresses issue and freezes the tap counters while high.
module conv_row_sequencer
    import conv_pkg::*;
#(
    parameter int ADDR_W = CONV_ADDR_W,
    parameter int DATA_W = CONV_DATA_W,
    parameter int K      = CONV_K
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    conv_run,
    input  logic [K*K*DATA_W-1:0]   kernel,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [ADDR_W-1:0]       num_rows,
`ifdef CONV_SEQ_STALL_EN
    input  logic                    stall,
`endif
    output logic                    ram_en,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [K*DATA_W-1:0]     weight,
    output logic                    w_valid,
    output logic                    acc_first,
    output logic                    acc_last,
    output logic                    busy,
    output logic                    done
);

    localparam int KW = $clog2(K);

    conv_state_e           state_q;
    logic [K*K*DATA_W-1:0] kernel_q;
    logic [ADDR_W-1:0]     base_q, rlast_q, r_q, r_d, ram_addr_q;
    logic [KW-1:0]         k_q, k_d;
    logic                  ram_en_q, done_q;
    logic                  last_k, last_tap, stall_w;

`ifdef CONV_SEQ_STALL_EN
    assign stall_w = stall;
`else
    assign stall_w = 1'b0;
`endif

    // Next tap in (r outer, k inner) order; counters hold the last issued tap.
    always_comb begin
        last_k   = (k_q == KW'(K-1));
        last_tap = last_k && (r_q == rlast_q);
        r_d      = last_k ? r_q + 1'b1 : r_q;
        k_d      = last_k ? '0 : k_q + 1'b1;
    end

    // Control FSM: start/latch, tap issue, one drain cycle, done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            kernel_q   <= '0;
            base_q     <= '0;
            rlast_q    <= '0;
            r_q        <= '0;
            k_q        <= '0;
            ram_en_q   <= 1'b0;
            ram_addr_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (conv_run) begin
                    kernel_q <= kernel;
                    base_q   <= base_addr;
                    rlast_q  <= num_rows - ADDR_W'(K);
                    r_q      <= '0;
                    k_q      <= '0;
                    if (num_rows >= ADDR_W'(K)) begin
                        state_q    <= S_ISSUE;
                        ram_en_q   <= 1'b1;
                        ram_addr_q <= base_addr;
                    end else begin
                        // Too few rows for even one output row: finish at once.
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (last_tap) begin
                        ram_en_q <= 1'b0;
                        state_q  <= S_DRAIN;
                    end else if (stall_w) begin
                        ram_en_q <= 1'b0;
                    end else begin
                        ram_en_q   <= 1'b1;
                        r_q        <= r_d;
                        k_q        <= k_d;
                        ram_addr_q <= base_q + r_d + ADDR_W'(k_d);
                    end
                end
                S_DRAIN: begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    conv_weight_align #(.DATA_W(DATA_W), .K(K), .KW(KW)) u_align (
        .clk         (clk),
        .rst         (rst),
        .tap_en_i    (ram_en_q),
        .tap_k_i     (k_q),
        .kernel_i    (kernel_q),
        .weight_o    (weight),
        .w_valid_o   (w_valid),
        .acc_first_o (acc_first),
        .acc_last_o  (acc_last)
    );

    assign ram_en   = ram_en_q;
    assign ram_addr = ram_addr_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_conv_row_sequencer.sv
// Randomized bench for conv_row_sequencer with a tap-list reference model.
module tb_conv_row_sequencer;

    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int KK   = 3;
    localparam int RW   = KK * DW;
    localparam int MAXC = 256;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              conv_run = 1'b0;
    logic [KK*KK*DW-1:0] kernel = '0;
    logic [AW-1:0]     base_addr = '0;
    logic [AW-1:0]     num_rows = '0;
`ifdef CONV_SEQ_STALL_EN
    logic              stall = 1'b0;
`endif
    logic              ram_en;
    logic [AW-1:0]     ram_addr;
    logic [RW-1:0]     weight;
    logic              w_valid, acc_first, acc_last, busy, done;

    int n_chk  = 0;
    int n_pass = 0;

    // expected per-cycle issue trace; stall_at[e] = stall seen at edge e
    bit            e_en   [MAXC];
    logic [AW-1:0] e_addr [MAXC];
    int            e_k    [MAXC];
    bit            stall_at [MAXC];

    always #5 clk = ~clk;

    conv_row_sequencer #(.ADDR_W(AW), .DATA_W(DW), .K(KK)) dut (
        .clk       (clk),
        .rst       (rst),
        .conv_run  (conv_run),
        .kernel    (kernel),
        .base_addr (base_addr),
        .num_rows  (num_rows),
`ifdef CONV_SEQ_STALL_EN
        .stall     (stall),
`endif
        .ram_en    (ram_en),
        .ram_addr  (ram_addr),
        .weight    (weight),
        .w_valid   (w_valid),
        .acc_first (acc_first),
        .acc_last  (acc_last),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [KK*KK*DW-1:0] rand_kern();
        logic [KK*KK*DW-1:0] v;
        for (int i = 0; i < KK*KK; i++) v[i*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    // Taps are the list (r, k) for r=0..nrows-K, k=0..K-1; one goes out per
    // unstalled cycle starting in cycle 1, then one drain cycle, then done.
    task automatic build_model(input logic [AW-1:0] base, input int nrows, output int d_cyc);
        int ntaps, idx, c;
        for (int i = 0; i < MAXC; i++) begin
            e_en[i] = 0; e_addr[i] = '0; e_k[i] = 0;
        end
        if (nrows < KK) begin
            d_cyc = 1;
            return;
        end
        ntaps = (nrows - KK + 1) * KK;
        idx = 0;
        c = 1;
        while (1) begin
            if (idx == ntaps) begin
                d_cyc = c + 1;
                break;
            end
            if (c == 1 || !stall_at[c-1]) begin
                e_en[c]   = 1;
                e_addr[c] = AW'(int'(base) + idx / KK + idx % KK);
                e_k[c]    = idx % KK;
                idx++;
            end
            c++;
        end
    endtask

    task automatic run_case(input logic [AW-1:0] base, input int nrows, input int reassert_c);
        logic [KK*KK*DW-1:0] kern;
        int d_cyc;
        kern = rand_kern();
        build_model(base, nrows, d_cyc);
        @(negedge clk);
        conv_run  = 1'b1;
        base_addr = base;
        num_rows  = AW'(nrows);
        kernel    = kern;
        for (int c = 1; c <= d_cyc + 2; c++) begin
            @(negedge clk);
            chk($sformatf("ram_en c%0d", c), 64'(ram_en), 64'(e_en[c]));
            if (e_en[c]) chk($sformatf("ram_addr c%0d", c), 64'(ram_addr), 64'(e_addr[c]));
            chk($sformatf("w_valid c%0d", c), 64'(w_valid), 64'(e_en[c-1]));
            if (e_en[c-1]) begin
                chk($sformatf("weight c%0d", c), 64'(weight), 64'(kern[(KK-1-e_k[c-1])*RW +: RW]));
                chk($sformatf("acc_first c%0d", c), 64'(acc_first), 64'(e_k[c-1] == 0));
                chk($sformatf("acc_last c%0d", c), 64'(acc_last), 64'(e_k[c-1] == KK-1));
            end else begin
                chk($sformatf("acc_first c%0d", c), 64'(acc_first), 64'(0));
                chk($sformatf("acc_last c%0d", c), 64'(acc_last), 64'(0));
            end
            chk($sformatf("done c%0d", c), 64'(done), 64'(c == d_cyc));
            chk($sformatf("busy c%0d", c), 64'(busy), 64'(c <= d_cyc));
            // scramble inputs after start; only the latched copies matter
            conv_run  = (c == reassert_c);
            base_addr = AW'($urandom);
            num_rows  = AW'($urandom);
            kernel    = rand_kern();
`ifdef CONV_SEQ_STALL_EN
            stall     = stall_at[c];
`endif
        end
        conv_run = 1'b0;
`ifdef CONV_SEQ_STALL_EN
        stall = 1'b0;
`endif
        for (int i = 0; i < MAXC; i++) stall_at[i] = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ram_en"},    64'(ram_en),    64'(0));
        chk({tag, " ram_addr"},  64'(ram_addr),  64'(0));
        chk({tag, " weight"},    64'(weight),    64'(0));
        chk({tag, " w_valid"},   64'(w_valid),   64'(0));
        chk({tag, " acc_first"}, 64'(acc_first), 64'(0));
        chk({tag, " acc_last"},  64'(acc_last),  64'(0));
        chk({tag, " busy"},      64'(busy),      64'(0));
        chk({tag, " done"},      64'(done),      64'(0));
    endtask

    initial begin
        for (int i = 0; i < MAXC; i++) stall_at[i] = 0;
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // basic walk, short run, address wrap, ignored re-start
        run_case(8'd0, 5, 0);
        run_case(8'd7, 2, 0);
        run_case(8'd254, 4, 0);
        run_case(8'd0, 5, 4);

        // reset mid-run abandons the run without a done pulse
        @(negedge clk);
        conv_run  = 1'b1;
        base_addr = 8'd0;
        num_rows  = 8'd5;
        kernel    = rand_kern();
        @(negedge clk);
        conv_run = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrun addr c5", 64'(ram_addr), 64'(2));
        #2 rst = 1'b0;
        #1 chk_all_zero("midrun reset");
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("reset hold done %0d", c), 64'(done), 64'(0));
            chk($sformatf("reset hold busy %0d", c), 64'(busy), 64'(0));
        end
        rst = 1'b1;
        run_case(8'd0, 5, 0);

`ifdef CONV_SEQ_STALL_EN
        stall_at[2] = 1;
        stall_at[3] = 1;
        run_case(8'd0, 5, 0);
`endif

        // randomized runs
        for (int t = 0; t < 12; t++) begin
`ifdef CONV_SEQ_STALL_EN
            for (int i = 2; i < 60; i++) stall_at[i] = ($urandom_range(0, 3) == 0);
`endif
            run_case(AW'($urandom), $urandom_range(0, 10), (t % 3 == 0) ? 3 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
